// File: rtl/display_scan_scheduler_pkg.sv
// Shared types and constants for the display scan scheduler.
// Holds the scan FSM encoding, the nibble width and a width helper.
package display_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  localparam int NIBBLE_W = 4;

  // Digit drive is active-low; this bit is replicated to switch every digit off.
  localparam logic DIGIT_OFF = 1'b1;

  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/display_scan_scheduler_if.sv
// Decoder/digit-drive side of the scan scheduler.
// The scheduler drives it through master; a display model or decoder listens through slave.
interface display_scan_scheduler_if #(
    parameter int NUM_DIGITS = 6
);
    logic [3:0]            dec_data;
    logic                  dec_mode;
    logic                  dec_enable;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic                  frame_done;
    logic                  blink_phase;

    modport master (
        output dec_data,
        output dec_mode,
        output dec_enable,
        output digit_sel,
        output frame_done,
        output blink_phase
    );

    modport slave (
        input dec_data,
        input dec_mode,
        input dec_enable,
        input digit_sel,
        input frame_done,
        input blink_phase
    );
endinterface

// File: rtl/display_scan_scheduler_scan_prescaler.sv
// Loadable down-counter for the slot timer; tc is high while the count is zero.
// A load takes priority over counting, so reloading on tc starts the next interval.
module scan_prescaler #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);
endmodule

// File: rtl/display_scan_scheduler.sv
// Scans NUM_DIGITS digit slots through one shared seven-segment decoder with
// blanking dead time, per-digit blink and frame-boundary content updates.
module display_scan_scheduler
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYC    = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]            mode_in,
    input  logic [NUM_DIGITS-1:0]            enable_in,
    input  logic [NUM_DIGITS-1:0]            blink_mask,
    input  logic                             load,
    output scan_state_t                      state_dbg,
    display_scan_scheduler_if.master         disp
);
    localparam int SLOT_W  = clog2_min1((SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC);
    localparam int IDX_W   = clog2_min1(NUM_DIGITS);
    localparam int FRAME_W = clog2_min1(BLINK_FRAMES);

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(BLINK_FRAMES - 1);
    localparam logic [SLOT_W-1:0]  DRIVE_LEN  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0]  BLANK_LEN  = SLOT_W'(BLANK_CYC - 1);

    scan_state_t state, state_n;
    logic [IDX_W-1:0]   index, index_n;
    logic [FRAME_W-1:0] frame_cnt;
    logic               blink_q;
    logic               wrap;
    logic               slot_tc;
    logic               pre_load;
    logic [SLOT_W-1:0]  pre_val;

    logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] shadow_data, pending_data;
    logic [NUM_DIGITS-1:0]               shadow_mode, pending_mode;
    logic [NUM_DIGITS-1:0]               shadow_en, pending_en;
    logic                                pending_flag;

    logic                  drive_n;
    logic [NUM_DIGITS-1:0] sel_n;

    // After reset the counter sits at zero, so the first blank lasts one cycle;
    // reset itself already held every digit dark.
    scan_prescaler #(
        .W(SLOT_W)
    ) u_slot_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pre_load),
        .load_val (pre_val),
        .tc       (slot_tc)
    );

    always_comb begin
        state_n  = state;
        index_n  = index;
        pre_load = 1'b0;
        pre_val  = '0;
        wrap     = 1'b0;
        case (state)
            ST_BLANK: begin
                if (slot_tc) begin
                    state_n  = ST_DRIVE;
                    pre_load = 1'b1;
                    pre_val  = DRIVE_LEN;
                end
            end
            ST_DRIVE: begin
                if (slot_tc) begin
                    state_n  = ST_BLANK;
                    pre_load = 1'b1;
                    pre_val  = BLANK_LEN;
                    if (index == LAST_IDX) begin
                        index_n = '0;
                        wrap    = 1'b1;
                    end else begin
                        index_n = index + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_n = ST_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BLANK;
            index <= '0;
        end else begin
            state <= state_n;
            index <= index_n;
        end
    end

    // A load coinciding with the wrap lands in pending and keeps the flag set,
    // so it is applied at the following wrap rather than this one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_data <= '0;
            pending_mode <= '0;
            pending_en   <= '0;
            pending_flag <= 1'b0;
            shadow_data  <= '0;
            shadow_mode  <= '0;
            shadow_en    <= '0;
        end else begin
            if (wrap && pending_flag) begin
                shadow_data <= pending_data;
                shadow_mode <= pending_mode;
                shadow_en   <= pending_en;
            end
            if (load) begin
                pending_data <= digits_in;
                pending_mode <= mode_in;
                pending_en   <= enable_in;
                pending_flag <= 1'b1;
            end else if (wrap) begin
                pending_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (wrap) begin
            if (frame_cnt == LAST_FRAME) begin
                frame_cnt <= '0;
                blink_q   <= ~blink_q;
            end else begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
        end
    end

    // Outputs are computed from the next state so registered drive lines up with the FSM.
    always_comb begin
        drive_n = (state_n == ST_DRIVE);
        sel_n   = {NUM_DIGITS{DIGIT_OFF}};
        if (drive_n) begin
            sel_n = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << index_n);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp.digit_sel  <= {NUM_DIGITS{DIGIT_OFF}};
            disp.dec_data   <= '0;
            disp.dec_mode   <= 1'b0;
            disp.dec_enable <= 1'b0;
            disp.frame_done <= 1'b0;
        end else begin
            disp.digit_sel  <= sel_n;
            disp.dec_data   <= drive_n ? shadow_data[index_n] : '0;
            disp.dec_mode   <= drive_n & shadow_mode[index_n];
            disp.dec_enable <= drive_n & shadow_en[index_n]
                               & ~(blink_mask[index_n] & blink_q);
            disp.frame_done <= wrap;
        end
    end

    assign disp.blink_phase = blink_q;
    assign state_dbg        = state;
endmodule

// File: tb/tb_display_scan_scheduler.sv
// Bench for display_scan_scheduler: a hand-computed table for the first frame,
// then a cycle-position model for load, wrap-load, blink and mid-drive reset.
module tb_display_scan_scheduler;
  import display_pkg::*;

  localparam int ND = 4;
  localparam int FRAME = 20;
  localparam int SLOT = 5;

  logic clk;
  logic rst_n;
  logic [15:0] digits_in;
  logic [3:0] mode_in;
  logic [3:0] enable_in;
  logic [3:0] blink_mask;
  logic load;
  scan_state_t state_dbg;

  display_scan_scheduler_if #(.NUM_DIGITS(ND)) disp_if ();

  display_scan_scheduler #(
    .NUM_DIGITS(ND),
    .SCAN_DIV(4),
    .BLANK_CYC(1),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .digits_in(digits_in),
    .mode_in(mode_in),
    .enable_in(enable_in),
    .blink_mask(blink_mask),
    .load(load),
    .state_dbg(state_dbg),
    .disp(disp_if)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  int n_checks;
  int n_fail;

  // content the bench expects the DUT to be showing in the current frame
  logic [15:0] cur_data;
  logic [3:0] cur_mode;
  logic [3:0] cur_en;

  typedef struct {
    logic [3:0] sel;
    logic en;
    logic fd;
    scan_state_t st;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: cyc %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_model();
    int p, k, j;
    logic drive;
    logic [3:0] e_sel;
    logic e_phase, e_en, e_fd;
    p = cyc % FRAME;
    k = p / SLOT;
    j = p % SLOT;
    drive = (j != 0);
    e_phase = ((cyc / FRAME) / 2) % 2 == 1;
    e_fd = (p == 0) && (cyc > 0);
    e_sel = drive ? ~(4'b0001 << k) : 4'hF;
    e_en = drive && cur_en[k] && !(blink_mask[k] && e_phase);
    chk("digit_sel", 16'(disp_if.digit_sel), 16'(e_sel));
    chk("dec_enable", 16'(disp_if.dec_enable), 16'(e_en));
    chk("frame_done", 16'(disp_if.frame_done), 16'(e_fd));
    chk("blink_phase", 16'(disp_if.blink_phase), 16'(e_phase));
    chk("state", 16'(state_dbg), 16'(drive ? ST_DRIVE : ST_BLANK));
    if (drive) begin
      chk("dec_data", 16'(disp_if.dec_data), 16'((cur_data >> (4 * k)) & 16'h000F));
      chk("dec_mode", 16'(disp_if.dec_mode), 16'(cur_mode[k]));
    end
  endtask

  // driver task: advance n cycles, checking every cycle against the model
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_model();
    end
  endtask

  task automatic set_content(input logic [15:0] d, input logic [3:0] m, input logic [3:0] e);
    cur_data = d;
    cur_mode = m;
    cur_en = e;
  endtask

  task automatic check_reset_values();
    chk("rst digit_sel", 16'(disp_if.digit_sel), 16'hF);
    chk("rst dec_data", 16'(disp_if.dec_data), 16'h0);
    chk("rst dec_mode", 16'(disp_if.dec_mode), 16'h0);
    chk("rst dec_enable", 16'(disp_if.dec_enable), 16'h0);
    chk("rst frame_done", 16'(disp_if.frame_done), 16'h0);
    chk("rst blink_phase", 16'(disp_if.blink_phase), 16'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    load = 1'b0;
    digits_in = '0;
    mode_in = '0;
    enable_in = '0;
    blink_mask = '0;
    set_content(16'h0, 4'h0, 4'h0);

    // first frame after reset, no content loaded
    vecs[0]  = '{4'hE, 1'b0, 1'b0, ST_DRIVE};  vecs[1]  = '{4'hE, 1'b0, 1'b0, ST_DRIVE};
    vecs[2]  = '{4'hE, 1'b0, 1'b0, ST_DRIVE};  vecs[3]  = '{4'hE, 1'b0, 1'b0, ST_DRIVE};
    vecs[4]  = '{4'hF, 1'b0, 1'b0, ST_BLANK};  vecs[5]  = '{4'hD, 1'b0, 1'b0, ST_DRIVE};
    vecs[6]  = '{4'hD, 1'b0, 1'b0, ST_DRIVE};  vecs[7]  = '{4'hD, 1'b0, 1'b0, ST_DRIVE};
    vecs[8]  = '{4'hD, 1'b0, 1'b0, ST_DRIVE};  vecs[9]  = '{4'hF, 1'b0, 1'b0, ST_BLANK};
    vecs[10] = '{4'hB, 1'b0, 1'b0, ST_DRIVE};  vecs[11] = '{4'hB, 1'b0, 1'b0, ST_DRIVE};
    vecs[12] = '{4'hB, 1'b0, 1'b0, ST_DRIVE};  vecs[13] = '{4'hB, 1'b0, 1'b0, ST_DRIVE};
    vecs[14] = '{4'hF, 1'b0, 1'b0, ST_BLANK};  vecs[15] = '{4'h7, 1'b0, 1'b0, ST_DRIVE};
    vecs[16] = '{4'h7, 1'b0, 1'b0, ST_DRIVE};  vecs[17] = '{4'h7, 1'b0, 1'b0, ST_DRIVE};
    vecs[18] = '{4'h7, 1'b0, 1'b0, ST_DRIVE};  vecs[19] = '{4'hF, 1'b0, 1'b1, ST_BLANK};
    vecs[20] = '{4'hE, 1'b0, 1'b0, ST_DRIVE};

    repeat (3) @(negedge clk);
    check_reset_values();
    chk("rst state", 16'(state_dbg), 16'(ST_BLANK));
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("tbl digit_sel", 16'(disp_if.digit_sel), 16'(vecs[i].sel));
      chk("tbl dec_enable", 16'(disp_if.dec_enable), 16'(vecs[i].en));
      chk("tbl frame_done", 16'(disp_if.frame_done), 16'(vecs[i].fd));
      chk("tbl state", 16'(state_dbg), 16'(vecs[i].st));
    end

    // load mid-frame: nothing changes until the wrap at cycle 40
    run_cycles(2);
    digits_in = 16'h4321;
    enable_in = 4'hF;
    mode_in = 4'h0;
    load = 1'b1;
    run_cycles(1);
    load = 1'b0;
    run_cycles(16);
    set_content(16'h4321, 4'h0, 4'hF);
    run_cycles(20);

    // two loads in one frame: the last one wins
    digits_in = 16'h1111;
    load = 1'b1;
    run_cycles(1);
    load = 1'b0;
    run_cycles(4);
    digits_in = 16'h9999;
    load = 1'b1;
    run_cycles(1);
    load = 1'b0;
    run_cycles(14);
    set_content(16'h9999, 4'h0, 4'hF);
    run_cycles(20);

    // load sampled on the wrap edge (cycle 120) waits one extra frame
    run_cycles(19);
    digits_in = 16'hAAAA;
    mode_in = 4'b0101;
    load = 1'b1;
    run_cycles(1);
    load = 1'b0;
    run_cycles(20);
    set_content(16'hAAAA, 4'b0101, 4'hF);
    run_cycles(20);

    // blink slot 1 across both phases
    blink_mask = 4'b0010;
    run_cycles(80);

    // asynchronous reset in the middle of slot 2's drive
    run_cycles(11);
    chk("pre-reset digit_sel", 16'(disp_if.digit_sel), 16'hB);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    set_content(16'h0, 4'h0, 4'h0);
    run_cycles(25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
